// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - 640x480@60Hz VGA timing generator with pixel-rate divider
module vga_sync #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] pos_h,
  output logic [9:0] pos_v,
  output logic       blank,
  output logic       pix_en,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             step;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             h_wrap;
  logic             v_wrap;

  assign step = (div == DIV_LAST);

  // Next coordinates; wraps are explicit compares against the totals.
  always_comb begin
    h_wrap = (pos_h == H_LAST);
    v_wrap = (pos_v == V_LAST);
    h_next = h_wrap ? 10'd0 : pos_h + 10'd1;
    v_next = pos_v;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : pos_v + 10'd1;
    end
  end

  // Pixel-rate divider; pix_en marks the clk in which the coordinates advanced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else if (step) begin
      div    <= '0;
      pix_en <= 1'b1;
    end else begin
      div    <= div + 1'b1;
      pix_en <= 1'b0;
    end
  end

  // Coordinates and decodes are registered together from the next position,
  // so sync/blank never lag the coordinates they accompany.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_h       <= 10'd0;
      pos_v       <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else if (step) begin
      pos_h       <= h_next;
      pos_v       <= v_next;
      hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
      vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
      blank       <= (h_next >= H_VIS) || (v_next >= V_VIS);
      frame_start <= h_wrap && v_wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - self-checking bench for vga_sync against a pixel-count model
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  bit check_en = 1'b0;

  // dut_a: default timing, CLK_DIV=2
  logic a_hs, a_vs, a_bl, a_pe, a_fs;
  logic [9:0] a_ph, a_pv;
  vga_sync dut_a (
    .clk(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs), .pos_h(a_ph), .pos_v(a_pv),
    .blank(a_bl), .pix_en(a_pe), .frame_start(a_fs));

  // dut_b: miniature timing (15x10), CLK_DIV=2
  logic b_hs, b_vs, b_bl, b_pe, b_fs;
  logic [9:0] b_ph, b_pv;
  vga_sync #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
             .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut_b (
    .clk(clk), .rst(rst), .hsync(b_hs), .vsync(b_vs), .pos_h(b_ph), .pos_v(b_pv),
    .blank(b_bl), .pix_en(b_pe), .frame_start(b_fs));

  // dut_c: miniature timing, CLK_DIV=1
  logic c_hs, c_vs, c_bl, c_pe, c_fs;
  logic [9:0] c_ph, c_pv;
  vga_sync #(.CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
             .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut_c (
    .clk(clk), .rst(rst), .hsync(c_hs), .vsync(c_vs), .pos_h(c_ph), .pos_v(c_pv),
    .blank(c_bl), .pix_en(c_pe), .frame_start(c_fs));

  // k = clock edges seen since reset released
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d actual=%0d required=%0d", name, k, act, exp);
    end
  endtask

  // Model: after k edges, n = k/div pixel steps have happened; the position is
  // n folded into the raster, and every decode follows from that position.
  task automatic model_check(input string nm, input int cd, input int hv, input int hf,
                             input int hsw, input int hb, input int vv, input int vf,
                             input int vsw, input int vb, input logic hs, input logic vs,
                             input logic [9:0] ph, input logic [9:0] pv, input logic bl,
                             input logic pe, input logic fs);
    int ht, vt, n, h, v;
    bit pe_e, fs_e;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    n  = k / cd;
    h  = n % ht;
    v  = (n / ht) % vt;
    pe_e = (k > 0) && (k % cd == 0);
    fs_e = pe_e && (n > 0) && (n % (ht * vt) == 0);
    cmp({nm, ".pos_h"}, int'(ph), h);
    cmp({nm, ".pos_v"}, int'(pv), v);
    cmp({nm, ".pix_en"}, int'(pe), int'(pe_e));
    cmp({nm, ".frame_start"}, int'(fs), int'(fs_e));
    cmp({nm, ".hsync"}, int'(hs), int'(!(h >= hv + hf && h < hv + hf + hsw)));
    cmp({nm, ".vsync"}, int'(vs), int'(!(v >= vv + vf && v < vv + vf + vsw)));
    cmp({nm, ".blank"}, int'(bl), int'(h >= hv || v >= vv));
    // consistency of decodes with the coordinates the DUT actually presents
    cmp({nm, ".hsync_vs_pos"}, int'(hs),
        int'(!(int'(ph) >= hv + hf && int'(ph) < hv + hf + hsw)));
    cmp({nm, ".blank_vs_pos"}, int'(bl), int'(int'(ph) >= hv || int'(pv) >= vv));
  endtask

  // Compare process: every negedge, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      model_check("a", 2, 640, 16, 96, 48, 480, 10, 2, 33,
                  a_hs, a_vs, a_ph, a_pv, a_bl, a_pe, a_fs);
      model_check("b", 2, 8, 2, 3, 2, 6, 1, 2, 1,
                  b_hs, b_vs, b_ph, b_pv, b_bl, b_pe, b_fs);
      model_check("c", 1, 8, 2, 3, 2, 6, 1, 2, 1,
                  c_hs, c_vs, c_ph, c_pv, c_bl, c_pe, c_fs);
    end
  end

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    @(negedge clk);
    while (k != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (k != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_k actual=%0d required=%0d", k, target);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // reset values, pinned by hand
    cmp("rst.pos_h", int'(a_ph), 0);
    cmp("rst.hsync", int'(a_hs), 1);
    cmp("rst.vsync", int'(a_vs), 1);
    cmp("rst.blank", int'(a_bl), 0);
    cmp("rst.pix_en", int'(a_pe), 0);
    check_en = 1'b1;
    rst = 1'b0;

    // hand-computed points that pin the model
    wait_k(150);  cmp("c.frame_start@150", int'(c_fs), 1);
                  cmp("c.pos_h@150", int'(c_ph), 0);
    wait_k(210);  cmp("b.vsync@line7", int'(b_vs), 0);
    wait_k(300);  cmp("b.frame_start@300", int'(b_fs), 1);
                  cmp("b.pos_v@300", int'(b_pv), 0);
                  cmp("b.blank@300", int'(b_bl), 0);
    wait_k(301);  cmp("b.frame_start@301", int'(b_fs), 0);
    wait_k(1280); cmp("a.pos_h@1280", int'(a_ph), 640);
                  cmp("a.blank@640", int'(a_bl), 1);
    wait_k(1310); cmp("a.hsync@655", int'(a_hs), 1);
    wait_k(1312); cmp("a.hsync@656", int'(a_hs), 0);
    wait_k(1502); cmp("a.hsync@751", int'(a_hs), 0);
    wait_k(1504); cmp("a.hsync@752", int'(a_hs), 1);
    wait_k(1600); cmp("a.pos_v@1600", int'(a_pv), 1);
                  cmp("a.pos_h@1600", int'(a_ph), 0);
    wait_k(3800); cmp("a.pos_h@3800", int'(a_ph), 300);
                  cmp("a.pos_v@3800", int'(a_pv), 2);

    // asynchronous reset mid-line
    #2 rst = 1'b1;
    #1;
    cmp("async.pos_h", int'(a_ph), 0);
    cmp("async.pos_v", int'(a_pv), 0);
    cmp("async.hsync", int'(a_hs), 1);
    cmp("async.vsync", int'(a_vs), 1);
    cmp("async.pix_en", int'(a_pe), 0);
    cmp("async.frame_start", int'(a_fs), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // a few more lines of default timing and many miniature frames under the model
    wait_k(6400);
    cmp("a.pos_v@6400", int'(a_pv), 4);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
